// File: rtl/sync_marker_capture_pkg.sv
// rtl/sync_marker_capture_pkg.sv - shared constants and FSM encoding for the sync-marker capture block
package sync_marker_capture_pkg;

  localparam int CNT_W_DEF = 20;
  // Wave length in samples sits at ARB_SIZE_IN[WLEN_LSB +: CNT_W] (byte count of 32-bit samples)
  localparam int WLEN_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    REPORT    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer for an async input with rise/fall pulse outputs
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/sync_marker_capture.sv
// rtl/sync_marker_capture.sv - captures marker rise/fall positions against a wrapping per-wave sample counter
module sync_marker_capture
  import sync_marker_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             CLK200,
  input  logic             RST_N,
  input  logic [31:0]      ARB_SIZE_IN,
  input  logic             ENABLE,
  input  logic             SYNC_IN,
  input  logic             ACK,
  output logic [CNT_W-1:0] CNT_OUT,
  output logic [CNT_W-1:0] START_OUT,
  output logic [CNT_W-1:0] END_OUT,
  output logic [CNT_W-1:0] WIDTH_OUT,
  output logic             CAP_VALID,
  output logic             OVERRUN
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cap_state_t       state_q;
  logic [CNT_W-1:0] wlen_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wlen_eff;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] width_calc;
  logic             sync_rise;
  logic             sync_fall;
  logic             unused_arb;

  assign unused_arb = ^ARB_SIZE_IN;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (CLK200),
    .rst_n    (RST_N),
    .async_in (SYNC_IN),
    .rise     (sync_rise),
    .fall     (sync_fall)
  );

  // The arming cycle already counts, so it wraps on the length being latched that same cycle.
  // WLEN = 0 makes wlen_eff - 1 all ones, i.e. natural wrap.
  assign wlen_eff = (state_q == IDLE) ? ARB_SIZE_IN[WLEN_LSB +: CNT_W] : wlen_q;
  assign cnt_next = (cnt_q == wlen_eff - ONE) ? '0 : cnt_q + ONE;

  // Modular distance; adding WLEN = 0 on wrap leaves plain CNT_W-bit subtraction.
  assign width_calc = cnt_q - START_OUT + ((cnt_q < START_OUT) ? wlen_q : '0);

  always_ff @(posedge CLK200 or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      wlen_q    <= '0;
      cnt_q     <= '0;
      START_OUT <= '0;
      END_OUT   <= '0;
      WIDTH_OUT <= '0;
      CAP_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (!ENABLE) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      CAP_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      case (state_q)
        IDLE: begin
          wlen_q  <= ARB_SIZE_IN[WLEN_LSB +: CNT_W];
          state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (sync_rise) begin
            START_OUT <= cnt_q;
            state_q   <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (sync_fall) begin
            END_OUT   <= cnt_q;
            WIDTH_OUT <= width_calc;
            CAP_VALID <= 1'b1;
            state_q   <= REPORT;
          end
        end
        REPORT: begin
          if (ACK) begin
            CAP_VALID <= 1'b0;
            if (sync_rise) begin
              START_OUT <= cnt_q;
              state_q   <= WAIT_FALL;
            end else begin
              state_q <= WAIT_RISE;
            end
          end else if (sync_rise) begin
            OVERRUN <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CNT_OUT = cnt_q;

endmodule

// File: tb/tb_sync_marker_capture.sv
// tb/tb_sync_marker_capture.sv - directed and randomized checks of sync_marker_capture against a cycle-arithmetic model
`timescale 1ns/1ps
module tb_sync_marker_capture;

  localparam int CW = 20;
  localparam int SW = 8;
  localparam int SS = 2;

  logic          CLK200 = 1'b0;
  logic          RST_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic          SYNC_IN = 1'b0;
  logic          ACK = 1'b0;
  logic [31:0]   ARB_SIZE_IN = 32'd0;
  logic [CW-1:0] CNT_OUT, START_OUT, END_OUT, WIDTH_OUT;
  logic          CAP_VALID, OVERRUN;
  logic [SW-1:0] s_cnt, s_start, s_end, s_width;
  logic          s_valid, s_overrun;

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     arm_cyc = 0;
  longint cur_w = longint'(1) << CW;
  int     rc, fc, a, len, gap, w;
  longint exp_start, exp_end;

  always #5 CLK200 = ~CLK200;

  sync_marker_capture #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .CLK200(CLK200), .RST_N(RST_N), .ARB_SIZE_IN(ARB_SIZE_IN), .ENABLE(ENABLE),
    .SYNC_IN(SYNC_IN), .ACK(ACK), .CNT_OUT(CNT_OUT), .START_OUT(START_OUT),
    .END_OUT(END_OUT), .WIDTH_OUT(WIDTH_OUT), .CAP_VALID(CAP_VALID), .OVERRUN(OVERRUN)
  );

  sync_marker_capture #(.SYNC_STAGES(SS), .CNT_W(SW)) dut_small (
    .CLK200(CLK200), .RST_N(RST_N), .ARB_SIZE_IN(ARB_SIZE_IN), .ENABLE(ENABLE),
    .SYNC_IN(SYNC_IN), .ACK(ACK), .CNT_OUT(s_cnt), .START_OUT(s_start),
    .END_OUT(s_end), .WIDTH_OUT(s_width), .CAP_VALID(s_valid), .OVERRUN(s_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK200);
      #1;
      cyc++;
    end
  endtask

  // Counter value in cycle n: samples elapsed since the arming edge, modulo the wave length.
  function automatic longint exp_cnt(input int n, input longint m);
    return longint'(n - arm_cyc + 1) % m;
  endfunction

  task automatic arm(input logic [31:0] bytes);
    ARB_SIZE_IN = bytes;
    ENABLE = 1'b1;
    step();
    arm_cyc = cyc;
    cur_w = (bytes[21:2] == 20'd0) ? (longint'(1) << CW) : longint'(bytes[21:2]);
    ARB_SIZE_IN = $urandom;
  endtask

  task automatic disarm();
    ENABLE = 1'b0;
    step();
  endtask

  task automatic wait_cnt(input longint t, input longint m);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (exp_cnt(cyc, m) != t && guard < 5000);
    if (guard >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cnt: count %0d never reached within 5000 cycles", t);
    end
  endtask

  task automatic do_ack();
    ACK = 1'b1;
    step();
    ACK = 1'b0;
  endtask

  // Drive a marker so its edges are detected when the count equals r and f.
  task automatic pulse(input longint r, input longint f);
    wait_cnt((r - SS + cur_w) % cur_w, cur_w);
    SYNC_IN = 1'b1;
    rc = cyc + SS;
    wait_cnt((f - SS + cur_w) % cur_w, cur_w);
    SYNC_IN = 1'b0;
    fc = cyc + SS;
    step(fc + 1 - cyc);
  endtask

  initial begin
    #1;
    check("rst_cnt", 32'(CNT_OUT), 32'd0);
    check("rst_start", 32'(START_OUT), 32'd0);
    check("rst_end", 32'(END_OUT), 32'd0);
    check("rst_width", 32'(WIDTH_OUT), 32'd0);
    check("rst_valid", 32'(CAP_VALID), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);
    #11;
    RST_N = 1'b1;
    step(2);

    // basic capture, WLEN = 16
    arm(32'h40);
    check("arm_cnt", 32'(CNT_OUT), 32'(exp_cnt(cyc, cur_w)));
    pulse(3, 9);
    check("basic_valid", 32'(CAP_VALID), 32'd1);
    check("basic_start", 32'(START_OUT), 32'd3);
    check("basic_end", 32'(END_OUT), 32'd9);
    check("basic_width", 32'(WIDTH_OUT), 32'd6);
    step(5);
    check("basic_hold", 32'(CAP_VALID), 32'd1);
    check("basic_cnt", 32'(CNT_OUT), 32'(exp_cnt(cyc, cur_w)));
    do_ack();
    check("basic_ack", 32'(CAP_VALID), 32'd0);

    // wrap-around pulse and counter 15 -> 0
    pulse(14, 2);
    check("wrap_start", 32'(START_OUT), 32'd14);
    check("wrap_end", 32'(END_OUT), 32'd2);
    check("wrap_width", 32'(WIDTH_OUT), 32'd4);
    wait_cnt(15, cur_w);
    check("wrap_cnt15", 32'(CNT_OUT), 32'd15);
    step();
    check("wrap_cnt0", 32'(CNT_OUT), 32'd0);
    do_ack();

    // overrun, then rise coincident with ACK
    pulse(3, 9);
    check("ovr_pre", 32'(OVERRUN), 32'd0);
    SYNC_IN = 1'b1;
    step(SS + 1);
    check("ovr_set", 32'(OVERRUN), 32'd1);
    check("ovr_start", 32'(START_OUT), 32'd3);
    check("ovr_end", 32'(END_OUT), 32'd9);
    check("ovr_valid", 32'(CAP_VALID), 32'd1);
    SYNC_IN = 1'b0;
    step(4);
    SYNC_IN = 1'b1;
    a = cyc;
    step(SS);
    ACK = 1'b1;
    exp_start = exp_cnt(cyc, cur_w);
    step();
    ACK = 1'b0;
    check("ackrise_start", 32'(START_OUT), 32'(exp_start));
    check("ackrise_valid", 32'(CAP_VALID), 32'd0);
    check("ackrise_ovr", 32'(OVERRUN), 32'd1);
    check("ackrise_end", 32'(END_OUT), 32'd9);
    SYNC_IN = 1'b0;
    fc = cyc + SS;
    step(SS + 1);
    check("ackrise_fvalid", 32'(CAP_VALID), 32'd1);
    check("ackrise_fend", 32'(END_OUT), 32'(exp_cnt(fc, cur_w)));
    check("ackrise_fwidth", 32'(WIDTH_OUT), 32'((fc - a - SS) % cur_w));
    do_ack();
    check("ovr_sticky", 32'(OVERRUN), 32'd1);
    disarm();
    check("ovr_clear", 32'(OVERRUN), 32'd0);

    // marker already high when arming
    SYNC_IN = 1'b1;
    step(5);
    arm(32'h40);
    step(20);
    check("high_noval", 32'(CAP_VALID), 32'd0);
    check("high_nostart", 32'(START_OUT), 32'(exp_start));
    SYNC_IN = 1'b0;
    step(3);
    pulse(5, 6);
    check("short_valid", 32'(CAP_VALID), 32'd1);
    check("short_start", 32'(START_OUT), 32'd5);
    check("short_end", 32'(END_OUT), 32'd6);
    check("short_width", 32'(WIDTH_OUT), 32'd1);
    do_ack();
    disarm();

    // ENABLE dropped in WAIT_FALL
    arm(32'h40);
    SYNC_IN = 1'b1;
    exp_start = exp_cnt(cyc + SS, cur_w);
    step(SS + 2);
    ENABLE = 1'b0;
    step();
    check("abort_cnt", 32'(CNT_OUT), 32'd0);
    check("abort_valid", 32'(CAP_VALID), 32'd0);
    check("abort_ovr", 32'(OVERRUN), 32'd0);
    check("abort_start", 32'(START_OUT), 32'(exp_start));
    SYNC_IN = 1'b0;
    step(3);

    // asynchronous reset mid-count
    arm(32'h40);
    step(7);
    check("prerst_cnt", 32'(CNT_OUT), 32'(exp_cnt(cyc, cur_w)));
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_cnt", 32'(CNT_OUT), 32'd0);
    check("arst_start", 32'(START_OUT), 32'd0);
    check("arst_end", 32'(END_OUT), 32'd0);
    check("arst_width", 32'(WIDTH_OUT), 32'd0);
    check("arst_valid", 32'(CAP_VALID), 32'd0);
    check("arst_ovr", 32'(OVERRUN), 32'd0);
    ENABLE = 1'b0;
    @(negedge CLK200);
    RST_N = 1'b1;
    step(2);

    // WLEN = 0: natural wrap (observed on the 8-bit instance)
    arm(32'h0);
    wait_cnt(8'hFC, 256);
    SYNC_IN = 1'b1;
    step(3);
    check("nat_cntff", 32'(s_cnt), 32'hFF);
    SYNC_IN = 1'b0;
    step();
    check("nat_cnt0", 32'(s_cnt), 32'h0);
    check("nat_main_cnt", 32'(CNT_OUT), 32'h100);
    step(2);
    check("nat_valid", 32'(s_valid), 32'd1);
    check("nat_start", 32'(s_start), 32'hFE);
    check("nat_end", 32'(s_end), 32'h01);
    check("nat_width", 32'(s_width), 32'd3);
    check("nat_main_start", 32'(START_OUT), 32'hFE);
    check("nat_main_end", 32'(END_OUT), 32'h101);
    check("nat_main_width", 32'(WIDTH_OUT), 32'd3);
    do_ack();
    disarm();

    // WLEN = 1 holds the counter
    arm(32'h4);
    for (int i = 0; i < 4; i++) begin
      check("wlen1_cnt", 32'(CNT_OUT), 32'd0);
      step();
    end
    disarm();

    // randomized lengths, offsets and widths
    for (int it = 0; it < 10; it++) begin
      w = $urandom_range(3, 40);
      arm(32'(w * 4));
      gap = $urandom_range(0, w);
      step(gap);
      SYNC_IN = 1'b1;
      a = cyc;
      len = $urandom_range(1, 2 * w);
      step(len);
      SYNC_IN = 1'b0;
      step(SS + 1);
      exp_start = exp_cnt(a + SS, cur_w);
      exp_end = exp_cnt(a + len + SS, cur_w);
      check("rnd_valid", 32'(CAP_VALID), 32'd1);
      check("rnd_start", 32'(START_OUT), 32'(exp_start));
      check("rnd_end", 32'(END_OUT), 32'(exp_end));
      check("rnd_width", 32'(WIDTH_OUT), 32'(len % w));
      do_ack();
      disarm();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sync_marker_capture.md
Name: sync_marker_capture

Overview:
- Receive-side counterpart of the arbitrary-waveform sync-marker generator.
- Samples an external, asynchronous sync/marker input against its own wrapping sample counter, which runs over one waveform length.
- Reports the counter positions of the marker's rising edge (start) and falling edge (end), plus the pulse width modulo the waveform length.
- Sits between the external trigger/sync connector and the control register block. Firmware uses it to measure loop-back marker placement.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on SYNC_IN (minimum 2)
CNT_W, 20, width of the sample counter and all position outputs (max 1M samples)

Ports:
CLK200  input  1  200 MHz sample clock; all logic on rising edge
RST_N  input  1  asynchronous active-low reset
ARB_SIZE_IN  input  32  waveform size in bytes; one-wave length = ARB_SIZE_IN[21:2]
ENABLE  input  1  capture enable; rising edge latches wave length and arms
SYNC_IN  input  1  external marker, asynchronous to CLK200
ACK  input  1  one-cycle acknowledge of a reported capture
CNT_OUT  output  CNT_W  current sample counter
START_OUT  output  CNT_W  counter value at the detected rising edge
END_OUT  output  CNT_W  counter value at the detected falling edge
WIDTH_OUT  output  CNT_W  (END_OUT - START_OUT) modulo wave length
CAP_VALID  output  1  capture result valid; held until ACK
OVERRUN  output  1  sticky: a rising edge arrived while a result was pending

Behaviour:
- Reset (RST_N low, async):
  - All outputs are 0.
  - Synchronizer flops and the edge-history register are 0.
  - FSM is in IDLE.
  - Latched wave length WLEN is 0.
- Synchronizer: SYNC_IN passes through SYNC_STAGES flops. Edges are detected against one further history flop. The total delay is not compensated. A position is the CNT_OUT value in the cycle the edge is detected.
- WLEN: ARB_SIZE_IN[21:2] is registered on the cycle ENABLE is first seen high. WLEN = 0 means 2^CNT_W, i.e. natural wrap.
- Counter:
  - Held at 0 while ENABLE is low.
  - While enabled, increments each cycle and wraps from WLEN-1 to 0.
  - WLEN = 1 holds the counter at 0.
- FSM states:
  - IDLE: leaves on ENABLE high and goes to WAIT_RISE. The first cycle is used to latch WLEN.
  - WAIT_RISE: on a synchronized rising edge, START_OUT <= CNT_OUT and go to WAIT_FALL. A marker already high at arming is ignored until it falls and rises again.
  - WAIT_FALL: on a synchronized falling edge, END_OUT <= CNT_OUT, WIDTH_OUT computed in the same cycle, CAP_VALID <= 1, go to REPORT.
  - REPORT: START_OUT, END_OUT and WIDTH_OUT are frozen.
    - A rising edge without ACK sets OVERRUN. Data is not overwritten.
    - ACK alone: CAP_VALID <= 0 next cycle, go to WAIT_RISE.
    - ACK in the same cycle as a rising edge: that edge is captured (START_OUT updated, go to WAIT_FALL) and OVERRUN is not set.
- Width arithmetic:
  - If END >= START, WIDTH = END - START.
  - Otherwise WIDTH = END + WLEN - START, computed in CNT_W+1 bits and truncated. With WLEN = 0 this is plain CNT_W-bit subtraction.
  - The shortest pulse (fall one cycle after rise) gives WIDTH = 1.
  - A marker longer than one waveform wraps silently; it is not flagged.
- ACK outside REPORT is ignored.
- ENABLE deasserted in any state:
  - Next cycle: FSM to IDLE; counter, CAP_VALID and OVERRUN cleared.
  - START_OUT, END_OUT and WIDTH_OUT keep their last values.
  - Re-enabling latches ARB_SIZE_IN afresh.
- OVERRUN is cleared only by reset or ENABLE low.
- Async reset mid-capture returns everything to reset values immediately. No partial result is reported.

Decomposition:
- Shared package: CNT_W default, FSM state encoding (IDLE, WAIT_RISE, WAIT_FALL, REPORT), and the wave-length extraction constant (bits 21:2).
- One sub-module: sync_edge_detect, covering the SYNC_STAGES-flop synchronizer and the rise/fall pulse outputs. It is reusable for other external trigger inputs.
- Counter, FSM and width arithmetic stay in the top level.

Test Plan:
- Basic capture:
  - Stimulus: ARB_SIZE_IN = 0x40 (WLEN = 16), ENABLE high; marker whose edges are detected at CNT = 3 (rise) and CNT = 9 (fall).
  - Required response: CAP_VALID = 1 with START = 3, END = 9, WIDTH = 6, held until ACK. After a one-cycle ACK, CAP_VALID = 0 the next cycle.
- Wrap-around:
  - Stimulus: WLEN = 16; rise detected at CNT = 14, fall at CNT = 2.
  - Required response: WIDTH = 4. CNT_OUT sequence 15 -> 0 observed.
- Overrun and simultaneous events:
  - Stimulus: while in REPORT, a second rise with no ACK.
  - Required response: OVERRUN = 1, START/END unchanged.
  - Stimulus: a later rise in the same cycle as ACK.
  - Required response: new START captured, OVERRUN stays 1 (sticky), no new overrun event.
- Marker high at arm:
  - Stimulus: SYNC_IN held high before ENABLE.
  - Required response: no capture until it falls and rises again. A one-cycle synchronized pulse gives WIDTH = 1.
- Mid-operation abort:
  - Stimulus: ENABLE dropped in WAIT_FALL.
  - Required response: CNT_OUT = 0, CAP_VALID = 0, OVERRUN = 0 next cycle.
  - Stimulus: RST_N pulsed low mid-count.
  - Required response: all outputs 0 immediately, without waiting for a clock edge.
- Wave-length corner cases:
  - Stimulus: ARB_SIZE_IN = 0 (WLEN = 0).
  - Required response: counter wraps 0xFFFFF -> 0; rise at 0xFFFFE, fall at 0x00001 gives WIDTH = 3.
  - Stimulus: ARB_SIZE_IN = 0x4 (WLEN = 1).
  - Required response: CNT_OUT stays 0.
